// File: rtl/hazard_stall_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl_pkg
// Shared definitions for the WISC-F24 decode-stage hazard controller:
//   - controller FSM state encoding
//   - stall lengths for each hazard class that forwarding cannot cover
//   - drain length after HLT, and a small max helper for the 2-bit N value
// ---------------------------------------------------------------------------
package hazard_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  // Stall cycles required by each hazard class.
  localparam logic [1:0] STALL_LOAD   = 2'd1;
  localparam logic [1:0] STALL_FLAG   = 2'd1;
  localparam logic [1:0] STALL_BR_EX  = 2'd2;
  localparam logic [1:0] STALL_BR_MEM = 2'd1;

  // Value loaded into rem on entering DRAIN: DRAIN spans rem = 2, 1, 0.
  localparam logic [1:0] DRAIN_REM    = 2'd2;

  function automatic logic [1:0] max2(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl_if
// Bundles the pipeline-stage signals seen by the hazard controller and the
// control outputs it returns to the pipeline.
//   master : pipeline side (drives stage info, receives enables/flush/bubble)
//   slave  : hazard controller side
// Signals:
//   if_id_*      instruction in decode (rs/rt ids, valid, operand/type flags)
//   id_ex_*      instruction in execute (rd, write_reg, mem_read, sets_flags)
//   ex_mem_*     instruction in memory (rd, write_reg)
//   branch_taken decode-stage branch resolved taken
//   pc_write, if_id_write, if_id_flush, id_ex_bubble, halted, stall_count
// ---------------------------------------------------------------------------
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 16
);

  logic [3:0]       if_id_rs;
  logic [3:0]       if_id_rt;
  logic             if_id_valid;
  logic             if_id_uses_rt;
  logic             if_id_is_store;
  logic             if_id_branch;
  logic             if_id_branch_reg;
  logic             if_id_halt;

  logic [3:0]       id_ex_rd;
  logic             id_ex_write_reg;
  logic             id_ex_mem_read;
  logic             id_ex_sets_flags;

  logic [3:0]       ex_mem_rd;
  logic             ex_mem_write_reg;

  logic             branch_taken;

  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             halted;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output if_id_rs, if_id_rt, if_id_valid, if_id_uses_rt, if_id_is_store,
           if_id_branch, if_id_branch_reg, if_id_halt,
           id_ex_rd, id_ex_write_reg, id_ex_mem_read, id_ex_sets_flags,
           ex_mem_rd, ex_mem_write_reg, branch_taken,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, halted, stall_count
  );

  modport slave (
    input  if_id_rs, if_id_rt, if_id_valid, if_id_uses_rt, if_id_is_store,
           if_id_branch, if_id_branch_reg, if_id_halt,
           id_ex_rd, id_ex_write_reg, id_ex_mem_read, id_ex_sets_flags,
           ex_mem_rd, ex_mem_write_reg, branch_taken,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, halted, stall_count
  );

endinterface

// File: rtl/hazard_stall_ctrl_hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
// Purely combinational: maps the decode/execute/memory stage information to
// the number of stall cycles N (0..2) required before the instruction in
// decode may proceed. N is the maximum over all hazard classes.
// Ports:
//   if_id_*  : decode instruction fields
//   id_ex_*  : execute-stage producer info
//   ex_mem_* : memory-stage producer info
//   need     : required stall cycles
// ---------------------------------------------------------------------------
module hazard_detect
  import hazard_stall_ctrl_pkg::*;
(
  input  logic [3:0] if_id_rs,
  input  logic [3:0] if_id_rt,
  input  logic       if_id_valid,
  input  logic       if_id_uses_rt,
  input  logic       if_id_is_store,
  input  logic       if_id_branch,
  input  logic       if_id_branch_reg,
  input  logic [3:0] id_ex_rd,
  input  logic       id_ex_write_reg,
  input  logic       id_ex_mem_read,
  input  logic       id_ex_sets_flags,
  input  logic [3:0] ex_mem_rd,
  input  logic       ex_mem_write_reg,
  output logic [1:0] need
);

  logic load_use;
  logic flag_dep;
  logic br_ex;
  logic br_mem;

  always_comb begin
    // Register ids are compared raw; R0 is not special, matching forwarding.
    // SW store data (rt) is exempt: MEM-to-MEM forwarding supplies it.
    load_use = id_ex_mem_read && id_ex_write_reg &&
               ((id_ex_rd == if_id_rs) ||
                ((id_ex_rd == if_id_rt) && if_id_uses_rt && !if_id_is_store));
    flag_dep = if_id_branch && id_ex_sets_flags;
    // BR reads rs in decode; the register bypass only reaches from MEM/WB,
    // so producers in EX and EX/MEM both have to be waited out.
    br_ex    = if_id_branch_reg && id_ex_write_reg && (id_ex_rd == if_id_rs);
    br_mem   = if_id_branch_reg && ex_mem_write_reg && (ex_mem_rd == if_id_rs);

    need = 2'd0;
    if (if_id_valid) begin
      if (load_use) need = max2(need, STALL_LOAD);
      if (flag_dep) need = max2(need, STALL_FLAG);
      if (br_ex)    need = max2(need, STALL_BR_EX);
      if (br_mem)   need = max2(need, STALL_BR_MEM);
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
// Decode-stage hazard controller for the five-stage WISC-F24 core.
// Holds PC and IF/ID and bubbles ID/EX for hazards forwarding cannot cover,
// flushes IF/ID on taken branches, drains the pipeline on HLT and keeps a
// saturating count of stall cycles.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : stage inputs and control outputs (hazard_stall_ctrl_if.slave)
// Outputs are combinational from the inputs and registered state, so a
// hazard is acted on in the cycle it is detected.
// ---------------------------------------------------------------------------
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hazard_stall_ctrl_if.slave   bus
);

  state_e           state_q, state_d;
  logic [1:0]       rem_q, rem_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [1:0]       need;
  logic             stall;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_bubble;

  hazard_detect u_detect (
    .if_id_rs         (bus.if_id_rs),
    .if_id_rt         (bus.if_id_rt),
    .if_id_valid      (bus.if_id_valid),
    .if_id_uses_rt    (bus.if_id_uses_rt),
    .if_id_is_store   (bus.if_id_is_store),
    .if_id_branch     (bus.if_id_branch),
    .if_id_branch_reg (bus.if_id_branch_reg),
    .id_ex_rd         (bus.id_ex_rd),
    .id_ex_write_reg  (bus.id_ex_write_reg),
    .id_ex_mem_read   (bus.id_ex_mem_read),
    .id_ex_sets_flags (bus.id_ex_sets_flags),
    .ex_mem_rd        (bus.ex_mem_rd),
    .ex_mem_write_reg (bus.ex_mem_write_reg),
    .need             (need)
  );

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    halted_d     = halted_q;
    stall        = 1'b0;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (need != 2'd0) begin
          // The detection cycle is itself the first stall cycle.
          stall = 1'b1;
          rem_d = need - 2'd1;
          if (need > 2'd1) state_d = ST_STALL;
        end else if (bus.branch_taken) begin
          if_id_flush = 1'b1;
        end else if (bus.if_id_halt && bus.if_id_valid) begin
          // HLT moves on into ID/EX this cycle; fetch is frozen from here on.
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          rem_d       = DRAIN_REM;
          state_d     = ST_DRAIN;
        end
      end

      ST_STALL: begin
        // Decode inputs are ignored; decode re-evaluates once back in RUN.
        stall = 1'b1;
        if (rem_q <= 2'd1) begin
          rem_d   = 2'd0;
          state_d = ST_RUN;
        end else begin
          rem_d = rem_q - 2'd1;
        end
      end

      ST_DRAIN: begin
        // Bubble keeps the HLT still held in IF/ID from being reissued.
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
        if (rem_q == 2'd0) begin
          state_d  = ST_HALTED;
          halted_d = 1'b1;
        end else begin
          rem_d = rem_q - 2'd1;
        end
      end

      ST_HALTED: begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end

      default: begin
        state_d = ST_RUN;
        rem_d   = 2'd0;
      end
    endcase

    if (stall) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      if_id_flush  = 1'b0;
    end
  end

  always_comb begin
    count_d = count_q;
    if (stall && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      rem_q    <= 2'd0;
      halted_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      halted_q <= halted_d;
      count_q  <= count_d;
    end
  end

  assign bus.pc_write     = pc_write;
  assign bus.if_id_write  = if_id_write;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_bubble = id_ex_bubble;
  assign bus.halted       = halted_q;
  assign bus.stall_count  = count_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_ctrl
// Directed bench for hazard_stall_ctrl: reset state, load-use, store-data
// exemption, BR stall lengths, flag-dependent branch with flush, HLT drain,
// reset aborting STALL and DRAIN, and stall counter saturation.
// ---------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  hazard_stall_ctrl_if #(.CNT_W(16)) bus ();

  hazard_stall_ctrl #(.CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.if_id_rs         = 4'd0;
    bus.if_id_rt         = 4'd0;
    bus.if_id_valid      = 1'b0;
    bus.if_id_uses_rt    = 1'b0;
    bus.if_id_is_store   = 1'b0;
    bus.if_id_branch     = 1'b0;
    bus.if_id_branch_reg = 1'b0;
    bus.if_id_halt       = 1'b0;
    bus.id_ex_rd         = 4'd0;
    bus.id_ex_write_reg  = 1'b0;
    bus.id_ex_mem_read   = 1'b0;
    bus.id_ex_sets_flags = 1'b0;
    bus.ex_mem_rd        = 4'd0;
    bus.ex_mem_write_reg = 1'b0;
    bus.branch_taken     = 1'b0;
  endtask

  // Checks the four hazard outputs in one go.
  task automatic chk_ctl(input string tag, input logic pcw, input logic ifw,
                         input logic fl, input logic bub);
    chk({tag, ".pc_write"},     bus.pc_write,     pcw);
    chk({tag, ".if_id_write"},  bus.if_id_write,  ifw);
    chk({tag, ".if_id_flush"},  bus.if_id_flush,  fl);
    chk({tag, ".id_ex_bubble"}, bus.id_ex_bubble, bub);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clear_in();
    rst_n = 1'b0;

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    chk_ctl("reset", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("reset.halted", bus.halted, 1'b0);
    chk("reset.count", bus.stall_count, 16'd0);
    rst_n = 1'b1;
    step();

    // ---------------- load-use: LW R3 in EX, ADD rs=3 in decode ----------------
    bus.id_ex_mem_read  = 1'b1;
    bus.id_ex_write_reg = 1'b1;
    bus.id_ex_rd        = 4'd3;
    bus.if_id_valid     = 1'b1;
    bus.if_id_rs        = 4'd3;
    bus.if_id_rt        = 4'd7;
    bus.if_id_uses_rt   = 1'b1;
    #1;
    chk_ctl("lu.detect", 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk("lu.count", bus.stall_count, 16'd1);
    // Bubble now in ID/EX, LW in EX/MEM: ADD proceeds.
    bus.id_ex_mem_read  = 1'b0;
    bus.id_ex_write_reg = 1'b0;
    bus.id_ex_rd        = 4'd0;
    bus.ex_mem_write_reg = 1'b1;
    bus.ex_mem_rd        = 4'd3;
    #1;
    chk_ctl("lu.after", 1'b1, 1'b1, 1'b0, 1'b0);

    // Load-use via rt operand.
    clear_in();
    bus.id_ex_mem_read  = 1'b1;
    bus.id_ex_write_reg = 1'b1;
    bus.id_ex_rd        = 4'd9;
    bus.if_id_valid     = 1'b1;
    bus.if_id_rs        = 4'd1;
    bus.if_id_rt        = 4'd9;
    bus.if_id_uses_rt   = 1'b1;
    #1;
    chk("lu_rt.bubble", bus.id_ex_bubble, 1'b1);
    step();
    chk("lu_rt.count", bus.stall_count, 16'd2);

    // Same hazard but decode slot empty: no stall.
    bus.if_id_valid = 1'b0;
    #1;
    chk_ctl("lu_invalid", 1'b1, 1'b1, 1'b0, 1'b0);

    // ---------------- store-data exemption ----------------
    clear_in();
    bus.id_ex_mem_read  = 1'b1;
    bus.id_ex_write_reg = 1'b1;
    bus.id_ex_rd        = 4'd3;
    bus.if_id_valid     = 1'b1;
    bus.if_id_rs        = 4'd4;
    bus.if_id_rt        = 4'd3;
    bus.if_id_uses_rt   = 1'b1;
    bus.if_id_is_store  = 1'b1;
    #1;
    chk_ctl("sw_exempt", 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk("sw_exempt.count", bus.stall_count, 16'd2);

    // ---------------- BR with producer in EX: 2 stall cycles ----------------
    clear_in();
    bus.id_ex_write_reg  = 1'b1;
    bus.id_ex_rd         = 4'd5;
    bus.if_id_valid      = 1'b1;
    bus.if_id_branch_reg = 1'b1;
    bus.if_id_rs         = 4'd5;
    #1;
    chk_ctl("br_ex.c1", 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    // Producer moved to EX/MEM, bubble in ID/EX; STALL holds regardless.
    bus.id_ex_write_reg  = 1'b0;
    bus.id_ex_rd         = 4'd0;
    bus.ex_mem_write_reg = 1'b1;
    bus.ex_mem_rd        = 4'd5;
    #1;
    chk_ctl("br_ex.c2", 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk("br_ex.count", bus.stall_count, 16'd4);
    bus.ex_mem_write_reg = 1'b0;
    bus.ex_mem_rd        = 4'd0;
    #1;
    chk_ctl("br_ex.release", 1'b1, 1'b1, 1'b0, 1'b0);

    // ---------------- BR with producer only in EX/MEM: 1 cycle ----------------
    bus.ex_mem_write_reg = 1'b1;
    bus.ex_mem_rd        = 4'd5;
    #1;
    chk_ctl("br_mem.c1", 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk("br_mem.count", bus.stall_count, 16'd5);
    bus.ex_mem_write_reg = 1'b0;
    #1;
    chk_ctl("br_mem.release", 1'b1, 1'b1, 1'b0, 1'b0);

    // BR with non-matching rd: no stall.
    bus.id_ex_write_reg = 1'b1;
    bus.id_ex_rd        = 4'd6;
    #1;
    chk_ctl("br_nomatch", 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk("br_nomatch.count", bus.stall_count, 16'd5);

    // ---------------- flag-dependent B, taken ----------------
    clear_in();
    bus.if_id_valid      = 1'b1;
    bus.if_id_branch     = 1'b1;
    bus.id_ex_sets_flags = 1'b1;
    bus.branch_taken     = 1'b1;
    #1;
    chk_ctl("flag.stall", 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk("flag.count", bus.stall_count, 16'd6);
    bus.id_ex_sets_flags = 1'b0;
    #1;
    chk_ctl("flag.flush", 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    chk("flag.count2", bus.stall_count, 16'd6);

    // ---------------- HLT drain ----------------
    clear_in();
    bus.if_id_valid = 1'b1;
    bus.if_id_halt  = 1'b1;
    #1;
    chk_ctl("hlt.detect", 1'b0, 1'b0, 1'b0, 1'b0);
    step();  // posedge 1
    chk_ctl("hlt.drain1", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("hlt.drain1.halted", bus.halted, 1'b0);
    step();  // posedge 2
    chk_ctl("hlt.drain2", 1'b0, 1'b0, 1'b0, 1'b1);
    step();  // posedge 3
    chk_ctl("hlt.drain3", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("hlt.drain3.halted", bus.halted, 1'b0);
    step();  // posedge 4
    chk("hlt.halted", bus.halted, 1'b1);
    chk_ctl("hlt.halted", 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) step();
    chk("hlt.held", bus.halted, 1'b1);
    chk("hlt.count", bus.stall_count, 16'd6);

    // Reset out of HALTED.
    clear_in();
    rst_n = 1'b0;
    #1;
    chk("hlt.reset.halted", bus.halted, 1'b0);
    chk("hlt.reset.count", bus.stall_count, 16'd0);
    rst_n = 1'b1;
    step();

    // ---------------- reset mid-DRAIN ----------------
    bus.if_id_valid = 1'b1;
    bus.if_id_halt  = 1'b1;
    #1;
    step();
    step();
    chk("drain_rst.pre", bus.id_ex_bubble, 1'b1);
    clear_in();
    rst_n = 1'b0;
    #1;
    chk_ctl("drain_rst", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("drain_rst.halted", bus.halted, 1'b0);
    rst_n = 1'b1;
    step();
    step();
    chk("drain_rst.stay", bus.halted, 1'b0);

    // ---------------- reset mid-STALL ----------------
    bus.id_ex_write_reg  = 1'b1;
    bus.id_ex_rd         = 4'd2;
    bus.if_id_valid      = 1'b1;
    bus.if_id_branch_reg = 1'b1;
    bus.if_id_rs         = 4'd2;
    #1;
    step();
    chk("stall_rst.pre", bus.stall_count, 16'd1);
    clear_in();
    rst_n = 1'b0;
    #1;
    chk_ctl("stall_rst", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("stall_rst.count", bus.stall_count, 16'd0);
    rst_n = 1'b1;
    step();

    // ---------------- counter saturation ----------------
    bus.id_ex_mem_read  = 1'b1;
    bus.id_ex_write_reg = 1'b1;
    bus.id_ex_rd        = 4'd3;
    bus.if_id_valid     = 1'b1;
    bus.if_id_rs        = 4'd3;
    #1;
    repeat (65534) step();
    chk("sat.fffe", bus.stall_count, 16'hFFFE);
    repeat (6) step();
    chk("sat.ffff", bus.stall_count, 16'hFFFF);
    chk("sat.bubble", bus.id_ex_bubble, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
